// File: rtl/rotary_input_conditioner.sv
// Rotary encoder front end: 2-flop synchronise, debounce, change pulse and sticky illegal flag.
// Optional push switch channel (press_pulse) is compiled in when ROTARY_PRESS_EN is defined.
module rotary_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rotary_a_raw,
    input  logic rotary_b_raw,
`ifdef ROTARY_PRESS_EN
    input  logic rotary_press_raw,
    output logic press_pulse,
`endif
    output logic rotary_inc_a,
    output logic rotary_inc_b,
    output logic change_pulse,
    output logic illegal_flag
);

`ifdef ROTARY_PRESS_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]            rawIn;
    logic [NCH-1:0]            sync1_q;
    logic [NCH-1:0]            sync2_q;
    logic [NCH-1:0]            clean_q;
    logic [NCH-1:0]            clean_d;
    logic [NCH-1:0]            cleanPrev_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_d;
    logic                      change_pulse_q;
    logic                      change_pulse_d;
    logic                      illegal_q;
    logic                      illegal_d;
    logic [1:0]                abToggle;

`ifdef ROTARY_PRESS_EN
    logic press_pulse_q;
    logic press_pulse_d;
    assign rawIn = {rotary_press_raw, rotary_b_raw, rotary_a_raw};
`else
    assign rawIn = {rotary_b_raw, rotary_a_raw};
`endif

    // Change and illegal detection look one cycle behind, so their outputs trail the clean levels.
    assign abToggle = clean_q[1:0] ^ cleanPrev_q[1:0];

    always_comb begin
        clean_d        = clean_q;
        cnt_d          = cnt_q;
        change_pulse_d = |abToggle;
        illegal_d      = illegal_q | (&abToggle);
        for (int ch = 0; ch < NCH; ch++) begin
            if (sync2_q[ch] == clean_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                clean_d[ch] = sync2_q[ch];
                cnt_d[ch]   = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

`ifdef ROTARY_PRESS_EN
    assign press_pulse_d = clean_q[2] & ~cleanPrev_q[2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            cnt_q          <= '0;
            clean_q        <= '0;
            cleanPrev_q    <= '0;
            change_pulse_q <= 1'b0;
            illegal_q      <= 1'b0;
`ifdef ROTARY_PRESS_EN
            press_pulse_q  <= 1'b0;
`endif
        end else begin
            sync1_q        <= rawIn;
            sync2_q        <= sync1_q;
            cnt_q          <= cnt_d;
            clean_q        <= clean_d;
            cleanPrev_q    <= clean_q;
            change_pulse_q <= change_pulse_d;
            illegal_q      <= illegal_d;
`ifdef ROTARY_PRESS_EN
            press_pulse_q  <= press_pulse_d;
`endif
        end
    end

    assign rotary_inc_a = clean_q[0];
    assign rotary_inc_b = clean_q[1];
    assign change_pulse = change_pulse_q;
    assign illegal_flag = illegal_q;
`ifdef ROTARY_PRESS_EN
    assign press_pulse  = press_pulse_q;
`endif

endmodule
